cba_add_scheduler: RTL and testbench
====================================

CBA_ADD_SCHEDULER -- requirements
Module: cba_add_scheduler

Interface
REQ-001 SHALL provide parameter: WIDTH, 16, operand width in bits; multiple of 4, at least 8.
REQ-002 SHALL derive NPASS = WIDTH/4, the number of 4-bit slice passes per operation.
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide ports: req0_valid / req1_valid  input  1  requester has an add pending.
REQ-006 SHALL provide ports: req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL provide ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL provide ports: req0_cin / req1_cin  input  1  carry-in.
REQ-009 SHALL provide ports: slice_a, slice_b  output  4  nibble driven to the external 4-bit carry-bypass adder.
REQ-010 SHALL provide port: slice_cin  output  1  carry driven to the adder slice.
REQ-011 SHALL provide ports: slice_sum  input  4, and slice_cout  input  1; combinational slice result.
REQ-012 SHALL provide ports: resp_valid  output  1, and resp_ready  input  1; response handshake.
REQ-013 SHALL provide ports: resp_sum  output  WIDTH, resp_cout  output  1, resp_id  output  1 (served requester).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: reqX_ready = 1 only for the granted requester, combinationally; at most one ready high per cycle.
REQ-016 Grant rule: if only one valid, grant it; if both valid, grant the requester not served last (round-robin pointer).
REQ-017 On the accept edge (valid and ready both high in IDLE), the block SHALL capture a, b, cin and id.
REQ-018 On the accept edge, the block SHALL clear the pass counter k to 0 and enter RUN.
REQ-019 RUN, pass k: slice_a = a[4k+3:4k], slice_b = b[4k+3:4k], slice_cin = carry register (the captured cin at k=0).
REQ-020 Each RUN edge SHALL write slice_sum into sum[4k+3:4k], load carry with slice_cout, and increment k.
REQ-021 At the edge completing pass NPASS-1, the FSM SHALL enter DONE; slice results are sampled only in RUN.
REQ-022 Latency: resp_valid SHALL be high NPASS cycles after the accept edge (4 for WIDTH=16).
REQ-023 DONE: resp_valid = 1; resp_sum, resp_cout (final carry) and resp_id SHALL be held stable until resp_ready is high.
REQ-024 DONE with resp_ready high: return to IDLE; set the round-robin pointer to resp_id.
REQ-025 No new request SHALL be accepted in the cycle the DONE to IDLE handshake completes.
REQ-026 No request SHALL be accepted in RUN or DONE; both reqX_ready SHALL be 0 in those states.
REQ-027 slice_a, slice_b and slice_cin SHALL be 0 outside RUN.
REQ-028 Requester inputs changing after the accept edge SHALL NOT affect the result.
REQ-029 Sum and carry arithmetic SHALL be modulo 2^WIDTH, with the carry-out reported on resp_cout.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and set k=0.
REQ-031 rst_n low SHALL immediately clear all outputs: ready, resp_valid, resp_sum, resp_cout, resp_id, slice_* = 0.
REQ-032 rst_n low SHALL set the round-robin pointer = 1, so req0 wins the first contention.
REQ-033 Reset asserted in RUN or DONE SHALL abandon the operation with no response issued.
REQ-034 The first edge after rst_n deasserts SHALL be able to accept a request.

Verification
REQ-035 req0 a=0x1234 b=0x4321 cin=0 (WIDTH=16) -> 4 cycles after accept: resp_sum=0x5555, resp_cout=0, resp_id=0.
REQ-036 req1 a=0xFFFF b=0x0001 cin=0 -> resp_sum=0x0000, resp_cout=1, resp_id=1; slice_cin=1 on passes 1-3.
REQ-037 req0 a=0x7FFF b=0x0000 cin=1 -> resp_sum=0x8000, resp_cout=0.
REQ-038 req0_valid and req1_valid held high from reset -> served in order 0,1,0,1; each grant has exactly one ready pulse.
REQ-039 resp_ready held low 3 cycles in DONE -> resp_* stable; both reqX_ready stay 0; completes on the 4th cycle.
REQ-040 rst_n pulsed low during pass 2 -> all outputs 0 immediately, no resp_valid; next request 0x0F0F+0x0101 -> 0x1010.

Source files
------------

// File: rtl/cba_add_scheduler.sv
// cba_add_scheduler
// Time-multiplexes one external 4-bit carry-bypass adder slice between two
// requesters. An accepted WIDTH-bit add is processed one nibble per cycle,
// least-significant first, with the carry rippled through a register.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid / _ready     request handshake (ready is combinational in IDLE)
//   req{0,1}_a, _b, _cin        operands and carry-in
//   slice_a, slice_b, slice_cin nibble operands driven to the adder slice
//   slice_sum, slice_cout       combinational result from the adder slice
//   resp_valid / resp_ready     response handshake
//   resp_sum, resp_cout         WIDTH-bit sum and final carry-out
//   resp_id                     requester that was served
module cba_add_scheduler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_cin,
    input  logic             req1_cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_id
);

    localparam int unsigned NPASS = WIDTH / 4;
    localparam int unsigned KW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [KW-1:0] KLast = KW'(NPASS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             id_q;
    logic             rr_q;      // requester served last

    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             in_run;
    logic [KW+1:0]    bit_base;

    // Round-robin arbitration: on contention favour the one not served last.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // rst_n gates ready so it drops immediately while reset is held.
    assign accept     = rst_n && (state_q == StIdle) && grant_valid;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign in_run    = (state_q == StRun);
    assign bit_base  = {k_q, 2'b00};
    assign slice_a   = in_run ? a_q[bit_base +: 4] : 4'h0;
    assign slice_b   = in_run ? b_q[bit_base +: 4] : 4'h0;
    assign slice_cin = in_run ? carry_q : 1'b0;

    assign resp_valid = (state_q == StDone);
    assign resp_sum   = sum_q;
    assign resp_cout  = carry_q;
    assign resp_id    = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            rr_q    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= grant_id ? req1_a : req0_a;
                        b_q     <= grant_id ? req1_b : req0_b;
                        carry_q <= grant_id ? req1_cin : req0_cin;
                        id_q    <= grant_id;
                        sum_q   <= '0;
                        k_q     <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[bit_base +: 4] <= slice_sum;
                    carry_q              <= slice_cout;
                    k_q                  <= k_q + 1'b1;
                    if (k_q == KLast) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        rr_q    <= id_q;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cba_add_scheduler.sv
// Directed testbench for cba_add_scheduler (WIDTH = 16). Provides a behavioural
// 4-bit adder slice and checks results against hand-computed values.
module tb_cba_add_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req1_cin;
    logic [3:0]  slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_cout;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_sum;
    logic        resp_cout, resp_id;

    int checks = 0;
    int errors = 0;

    cba_add_scheduler #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_cin   (req0_cin),
        .req1_cin   (req1_cin),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id)
    );

    // External 4-bit adder slice
    logic [4:0] slice_res;
    assign slice_res  = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};
    assign slice_sum  = slice_res[3:0];
    assign slice_cout = slice_res[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starts at a negedge; returns at a negedge. lat = posedges from accept to
    // resp_valid, or -1 if no response within the budget.
    task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input bit cin, input bit release_resp,
                          output logic [15:0] sum, output bit cout, output bit rid,
                          output int lat, output bit got_ready, output logic [3:0] cin_trace);
        cin_trace = 4'h0;
        sum = 16'h0;
        cout = 1'b0;
        rid = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        #1;
        got_ready = id ? req1_ready : req0_ready;
        @(negedge clk);
        // Scramble operands after the accept edge; must not affect the result.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_cin = 1'b1;
        req1_a = 16'hA5A5; req1_b = 16'h5A5A; req1_cin = 1'b1;
        lat = 0;
        for (int n = 0; n < 20 && !resp_valid; n++) begin
            if (lat < 4) cin_trace[lat[1:0]] = slice_cin;
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            lat = -1;
        end else begin
            sum = resp_sum; cout = resp_cout; rid = resp_id;
            if (release_resp) begin
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = 16'h0; req0_b = 16'h0; req0_cin = 1'b0;
        req1_a = 16'h0; req1_b = 16'h0; req1_cin = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_sum !== 16'h0 || resp_cout !== 1'b0 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got v=%b s=%h c=%b id=%b want all 0",
                     resp_valid, resp_sum, resp_cout, resp_id);
        end
        checks++;
        if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_slice got a=%h b=%h c=%b want 0", slice_a, slice_b, slice_cin);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        logic [15:0] s; bit c, r, g; int lat; logic [3:0] tr;
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, s, c, r, lat, g, tr);
        checks++;
        if (g !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", g); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
        checks++;
        if (s !== 16'h5555 || c !== 1'b0 || r !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got s=%h c=%b id=%b want 5555 0 0", s, c, r);
        end
        #1;
        checks++;
        if (resp_valid !== 1'b0 || slice_a !== 4'h0 || slice_b !== 4'h0 || slice_cin !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got v=%b a=%h b=%h c=%b want 0", resp_valid, slice_a,
                     slice_b, slice_cin);
        end
    endtask

    task automatic test_carry_chain();
        logic [15:0] s; bit c, r, g; int lat; logic [3:0] tr;
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, s, c, r, lat, g, tr);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1 || r !== 1'b1 || lat != 4) begin
            errors++;
            $display("FAIL carry_result got s=%h c=%b id=%b lat=%0d want 0000 1 1 4", s, c, r, lat);
        end
        checks++;
        if (tr !== 4'b1110) begin
            errors++;
            $display("FAIL carry_slice_cin got %b want 1110", tr);
        end
        run_op(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1, s, c, r, lat, g, tr);
        checks++;
        if (s !== 16'h8000 || c !== 1'b0 || r !== 1'b0) begin
            errors++;
            $display("FAIL cin_result got s=%h c=%b id=%b want 8000 0 0", s, c, r);
        end
        checks++;
        if (tr !== 4'b1111) begin
            errors++;
            $display("FAIL cin_slice_cin got %b want 1111", tr);
        end
    endtask

    task automatic test_stall();
        logic [15:0] s; bit c, r, g; int lat; logic [3:0] tr;
        run_op(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, r, lat, g, tr);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL stall_latency got %0d want 4", lat); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 16'h0001; req0_b = 16'h0001; req1_a = 16'h0002; req1_b = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_sum !== 16'h0100 || resp_cout !== 1'b0 ||
                resp_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got v=%b s=%h c=%b id=%b rdy=%b%b want 1 0100 0 1 00",
                         i, resp_valid, resp_sum, resp_cout, resp_id, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++; $display("FAIL stall_4th got v=%b want 1", resp_valid);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        // Back in IDLE; req1 was served last so req0 wins contention.
        checks++;
        if (resp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got v=%b rdy=%b%b want 0 10", resp_valid, req0_ready,
                     req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int grants[4];
        int ids[4];
        logic [15:0] sums[4];
        int ng = 0;
        int nr = 0;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
        req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 60 && nr < 4; n++) begin
            #1;
            checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                errors++; $display("FAIL rr_one_ready cyc %0d got 11 want at most one", n);
            end
            if ((req0_ready === 1'b1 || req1_ready === 1'b1) && ng < 4) begin
                grants[ng] = (req1_ready === 1'b1) ? 1 : 0;
                ng++;
            end
            if (resp_valid === 1'b1) begin
                ids[nr] = int'(resp_id);
                sums[nr] = resp_sum;
                nr++;
            end
            if (nr < 4) @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (ng != 4 || nr != 4) begin
            errors++; $display("FAIL rr_counts got grants=%0d resps=%0d want 4 4", ng, nr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < ng && i < nr &&
                (grants[i] != (i % 2) || ids[i] != (i % 2) ||
                 sums[i] !== ((i % 2) ? 16'h0030 : 16'h0003))) begin
                errors++;
                $display("FAIL rr_order %0d got grant=%0d id=%0d sum=%h want %0d %0d %h", i,
                         grants[i], ids[i], sums[i], i % 2, i % 2,
                         (i % 2) ? 16'h0030 : 16'h0003);
            end
        end
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; bit c, r, g; int lat; logic [3:0] tr;
        int seen = 0;
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (slice_a !== 4'h1 || slice_b !== 4'h2 || resp_sum !== 16'h0033) begin
            errors++;
            $display("FAIL mid_pass2 got a=%h b=%h s=%h want 1 2 0033", slice_a, slice_b, resp_sum);
        end
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_sum !== 16'h0 || resp_cout !== 1'b0 || resp_id !== 1'b0 ||
            slice_a !== 4'h0 || slice_b !== 4'h0 || slice_cin !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got v=%b s=%h c=%b id=%b a=%h b=%h ci=%b rdy=%b%b want 0",
                     resp_valid, resp_sum, resp_cout, resp_id, slice_a, slice_b, slice_cin,
                     req0_ready, req1_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mid_no_resp got %0d want 0", seen); end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        run_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b1, s, c, r, lat, g, tr);
        checks++;
        if (g !== 1'b1 || lat != 4 || s !== 16'h1010 || c !== 1'b0 || r !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got rdy=%b lat=%0d s=%h c=%b id=%b want 1 4 1010 0 0",
                     g, lat, s, c, r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_stall();
        test_round_robin();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
